// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_io_pkg
// Description : Shared constants and types for the memory-mapped I/O
//               responder: register offsets, STATUS/CTRL bit positions,
//               the CTRL write-data view and a count-saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

    // Register offsets inside the 4-word window
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 7;
    localparam int ST_WRAP   = 8;

    // CTRL bit positions
    localparam int CTRL_TIMER_EN  = 0;
    localparam int CTRL_CLR_FLAGS = 1;
    localparam int CTRL_IRQ_EN    = 2;

    // View of the low CTRL bits (bit2 .. bit0)
    typedef struct packed {
        logic irq_en;
        logic clr_flags;
        logic timer_en;
    } ctrl_t;

    // STATUS count field is only 4 bits wide; deeper FIFOs report 15
    function automatic logic [3:0] sat_count4(input logic [4:0] cnt);
        return (cnt > 5'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage : mem_io_pkg
`default_nettype wire

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Interface   : mem_io_responder_if
// Description : CPU memory-bus signals (en/rd_en/wr_en/addr/din/dout/hit)
//               plus the TX valid/ready stream of the I/O responder.
//               master : bus driver / stream sink (CPU side + sink)
//               slave  : the responder
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_responder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  en;
    logic                  rd_en;
    logic                  wr_en;
    logic [15:0]           din;
    logic [15:0]           dout;
    logic                  hit;
    logic                  tx_valid;
    logic [15:0]           tx_data;
    logic                  tx_ready;

    modport master (
        output addr, en, rd_en, wr_en, din, tx_ready,
        input  dout, hit, tx_valid, tx_data
    );

    modport slave (
        input  addr, en, rd_en, wr_en, din, tx_ready,
        output dout, hit, tx_valid, tx_data
    );
endinterface : mem_io_responder_if
`default_nettype wire

// File: rtl/mem_io_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_fifo
// Description : Synchronous FIFO with extra-MSB pointers (natural wrap).
//               A pop on an empty FIFO is ignored; a push on a full FIFO is
//               accepted only when a pop frees a slot in the same cycle.
// Ports       : clk, rst_n (async, active low)
//               push/push_data, pop, full, empty, count, head (= mem[rd_ptr])
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(DEPTH):0]          count,
    output logic [WIDTH-1:0]                head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_pop_ok  = pop & ~empty;
    // Full + simultaneous pop still has room for the new word
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            // Storage is cleared so the stream data output reads 0 after reset
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule : mem_io_fifo
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Memory-mapped I/O responder on the 16-bit CPU bus.
//               Window BASE_ADDR..BASE_ADDR+3: DATA (push to TX FIFO),
//               STATUS, TIMER, CTRL. Reads have 1-cycle latency (hit/dout).
// Ports       : clk, rst_n (async, active low)
//               bus : mem_io_responder_if.slave (bus + TX stream)
//               irq : only when MEM_IO_RESPONDER_IRQ_EN is defined
// Options     : MEM_IO_RESPONDER_IRQ_EN - adds registered irq output
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hFFC,
    parameter int                    FIFO_DEPTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_io_responder_if.slave bus
`ifdef MEM_IO_RESPONDER_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Decode
    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_pop;
    logic        w_load;
    logic        w_ctrl_wr;
    ctrl_t       w_ctrl_din;
    logic        w_clr;
    logic        w_drop;
    logic        w_wrap_evt;

    // FIFO
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic [15:0] w_head;

    // State
    logic [15:0] r_timer;
    logic        r_timer_en;
    logic        r_irq_en;
    logic        r_ovf;
    logic        r_wrap;
    logic [15:0] r_dout;
    logic        r_hit;

    logic [15:0] w_status;
    logic [15:0] w_ctrl_rd;
    logic [15:0] w_rdata;

    assign w_sel  = bus.en & (bus.addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
    assign w_off  = bus.addr[1:0];
    assign w_wr   = w_sel & bus.wr_en;
    assign w_rd   = w_sel & bus.rd_en & ~bus.wr_en;

    assign w_push     = w_wr & (w_off == OFF_DATA);
    assign w_pop      = ~w_empty & bus.tx_ready;
    assign w_load     = w_wr & (w_off == OFF_TIMER);
    assign w_ctrl_wr  = w_wr & (w_off == OFF_CTRL);
    assign w_ctrl_din = ctrl_t'(bus.din[2:0]);
    assign w_clr      = w_ctrl_wr & w_ctrl_din.clr_flags;
    assign w_drop     = w_push & w_full & ~w_pop;
    // A load replaces the increment, so it cannot cause a wrap
    assign w_wrap_evt = ~w_load & r_timer_en & (r_timer == 16'hFFFF);

    mem_io_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (bus.din),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    assign bus.tx_valid = ~w_empty;
    assign bus.tx_data  = w_head;
    assign bus.dout     = r_dout;
    assign bus.hit      = r_hit;

    always_comb begin
        w_status                       = '0;
        w_status[ST_EMPTY]             = w_empty;
        w_status[ST_FULL]              = w_full;
        w_status[ST_OVF]               = r_ovf;
        w_status[ST_CNT_HI:ST_CNT_LO]  = sat_count4(5'(w_count));
        w_status[ST_WRAP]              = r_wrap;

        w_ctrl_rd                      = '0;
        w_ctrl_rd[CTRL_TIMER_EN]       = r_timer_en;
        w_ctrl_rd[CTRL_IRQ_EN]         = r_irq_en;
    end

    // Read mux sees pre-update state of the request edge
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_DATA:   w_rdata = '0;
            OFF_STATUS: w_rdata = w_status;
            OFF_TIMER:  w_rdata = r_timer;
            OFF_CTRL:   w_rdata = w_ctrl_rd;
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer    <= '0;
            r_timer_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
            r_wrap     <= 1'b0;
            r_dout     <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_hit <= w_rd;
            if (w_rd) begin
                r_dout <= w_rdata;
            end

            if (w_load) begin
                r_timer <= bus.din;
            end else if (r_timer_en) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_ctrl_wr) begin
                r_timer_en <= w_ctrl_din.timer_en;
                r_irq_en   <= w_ctrl_din.irq_en;
            end

            // A drop and a clear cannot share a cycle (one bus access)
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end

            // A wrap coinciding with a clear is kept so the event is not lost
            if (w_wrap_evt) begin
                r_wrap <= 1'b1;
            end else if (w_clr) begin
                r_wrap <= 1'b0;
            end
        end
    end

`ifdef MEM_IO_RESPONDER_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & (r_wrap | r_ovf);
        end
    end

    assign irq = r_irq;
`endif

endmodule : mem_io_responder
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Self-checking bench for mem_io_responder. Directed scenarios
//               followed by random bus/stream traffic, all compared against a
//               queue-based reference model of the register/FIFO behaviour.
// Options     : MEM_IO_RESPONDER_IRQ_EN - also connects and checks irq
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;
    import mem_io_pkg::*;

    localparam int          AW    = 12;
    localparam logic [11:0] BASE  = 12'hFFC;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_io_responder_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef MEM_IO_RESPONDER_IRQ_EN
    logic irq;
`endif

    mem_io_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef MEM_IO_RESPONDER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q[$];
    bit          m_ovf, m_wrap, m_ten, m_ien, m_hit, m_irq;
    logic [15:0] m_timer, m_dout;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_wrap = 0; m_ten = 0; m_ien = 0; m_hit = 0; m_irq = 0;
        m_timer = 16'h0; m_dout = 16'h0;
    endtask

    function automatic logic [15:0] model_status();
        int n;
        n = q.size();
        return 16'((n == 0) ? 1 : 0) |
               16'((n == DEPTH) ? 2 : 0) |
               16'(m_ovf ? 4 : 0) |
               16'(((n > 15) ? 15 : n) * 16) |
               16'(m_wrap ? 256 : 0);
    endfunction

    function automatic logic [15:0] model_reg(input logic [1:0] off);
        case (off)
            OFF_STATUS: return model_status();
            OFF_TIMER:  return m_timer;
            OFF_CTRL:   return 16'((m_ten ? 1 : 0) + (m_ien ? 4 : 0));
            default:    return 16'h0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, advance model, check at next negedge
    task automatic cycle(input bit e, input bit rd, input bit wr, input logic [11:0] a,
                         input logic [15:0] d, input bit rdy);
        bit sel, w, r, wrapped;
        logic [1:0] off;
        bus.en = e; bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.din = d;
        bus.tx_ready = rdy;

        sel = e && (a[11:2] == BASE[11:2]);
        off = a[1:0];
        w   = sel && wr;
        r   = sel && rd && !wr;
        wrapped = 0;
        m_irq = m_ien && (m_wrap || m_ovf);
        if (r) m_dout = model_reg(off);
        m_hit = r;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (w && off == OFF_DATA) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovf = 1;
        end
        if (w && off == OFF_TIMER) m_timer = d;
        else if (m_ten) begin
            if (m_timer == 16'hFFFF) wrapped = 1;
            m_timer = m_timer + 16'd1;
        end
        if (w && off == OFF_CTRL) begin
            if (d[1]) begin m_ovf = 0; m_wrap = 0; end
            m_ten = d[0];
            m_ien = d[2];
        end
        if (wrapped) m_wrap = 1;

        @(posedge clk);
        @(negedge clk);
        check_val("hit", 32'(bus.hit), 32'(m_hit));
        check_val("dout", 32'(bus.dout), 32'(m_dout));
        check_val("tx_valid", 32'(bus.tx_valid), 32'(q.size() > 0));
        if (q.size() > 0) check_val("tx_data", 32'(bus.tx_data), 32'(q[0]));
`ifdef MEM_IO_RESPONDER_IRQ_EN
        check_val("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [15:0] d, input bit rdy);
        cycle(1, 0, 1, {BASE[11:2], off}, d, rdy);
    endtask

    task automatic rd_reg(input logic [1:0] off, input bit rdy);
        cycle(1, 1, 0, {BASE[11:2], off}, 16'h0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, 0, 12'h000, 16'h0, rdy);
    endtask

    initial begin
        logic [15:0] rd_val;
        rst_n = 1'b0;
        bus.en = 0; bus.rd_en = 0; bus.wr_en = 0; bus.addr = '0; bus.din = '0;
        bus.tx_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_dout", 32'(bus.dout), 32'h0);
        check_val("rst_hit", 32'(bus.hit), 32'h0);
        check_val("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_val("rst_tx_data", 32'(bus.tx_data), 32'h0);
        rst_n = 1'b1;

        // Empty status after reset
        rd_reg(OFF_STATUS, 0);
        check_val("status_reset", 32'(bus.dout), 32'h0001);

        // Two pushes, then drain
        wr_reg(OFF_DATA, 16'hA5A5, 0);
        wr_reg(OFF_DATA, 16'h1234, 0);
        rd_reg(OFF_STATUS, 0);
        check_val("status_two", 32'(bus.dout), 32'h0020);
        idle(1);
        idle(1);
        rd_reg(OFF_STATUS, 0);
        check_val("status_drained", 32'(bus.dout), 32'h0001);

        // Overflow: 9 writes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) wr_reg(OFF_DATA, 16'h0100 + 16'(i), 0);
        rd_reg(OFF_STATUS, 0);
        check_val("status_ovf", 32'(bus.dout), 32'h0086);
        wr_reg(OFF_CTRL, 16'h0002, 0);
        rd_reg(OFF_STATUS, 0);
        check_val("status_ovf_clr", 32'(bus.dout), 32'h0082);
        for (int i = 0; i < 10; i++) idle(1);

        // Full + simultaneous push/pop
        for (int i = 0; i < 8; i++) wr_reg(OFF_DATA, 16'h0200 + 16'(i), 0);
        wr_reg(OFF_DATA, 16'h00FF, 1);
        rd_reg(OFF_STATUS, 0);
        check_val("status_full_pp", 32'(bus.dout), 32'h0082);
        for (int i = 0; i < 7; i++) idle(1);
        check_val("last_out", 32'(bus.tx_data), 32'h00FF);
        idle(1);

        // Push + pop while empty
        wr_reg(OFF_DATA, 16'h0BEE, 1);
        check_val("empty_pp_valid", 32'(bus.tx_valid), 32'h1);
        idle(1);

        // Timer wrap
        wr_reg(OFF_TIMER, 16'hFFFE, 0);
        wr_reg(OFF_CTRL, 16'h0005, 0);
        idle(0);
        idle(0);
        rd_reg(OFF_STATUS, 0);
        check_val("status_wrap", 32'(bus.dout & 16'h0100), 32'h0100);
        rd_reg(OFF_TIMER, 0);
        wr_reg(OFF_CTRL, 16'h0002, 0);
        idle(0);
        rd_reg(OFF_CTRL, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit          e, rd, wr, rdy;
            logic [11:0] a;
            logic [15:0] d;
            e   = ($urandom % 8) != 0;
            rd  = $urandom % 2;
            wr  = $urandom % 2;
            a   = (($urandom % 5) != 0) ? {BASE[11:2], 2'($urandom % 4)} : 12'($urandom);
            d   = (($urandom % 8) == 0) ? 16'hFFFD : 16'($urandom);
            rdy = ($urandom % 3) == 0;
            cycle(e, rd, wr, a, d, rdy);
        end

        // Reset during drain and during an outstanding read
        for (int i = 0; i < 4; i++) wr_reg(OFF_DATA, 16'h0300 + 16'(i), 0);
        bus.en = 1; bus.rd_en = 1; bus.wr_en = 0; bus.addr = {BASE[11:2], OFF_TIMER};
        bus.tx_ready = 1;
        @(posedge clk);
        #1;
        check_val("pre_rst_hit", 32'(bus.hit), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_hit", 32'(bus.hit), 32'h0);
        check_val("mid_rst_dout", 32'(bus.dout), 32'h0);
        check_val("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_val("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
        rst_n = 1'b1;
        model_reset();
        bus.en = 0; bus.rd_en = 0; bus.tx_ready = 0;
        @(negedge clk);
        rd_reg(OFF_STATUS, 0);
        rd_val = bus.dout;
        check_val("status_after_rst", 32'(rd_val), 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule : tb_mem_io_responder
`default_nettype wire

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-mapped I/O responder on the CPU's single-port 16-bit memory bus (en/rd_en/wr_en/addr/din/dout).
- Sits beside memory; the top level routes CPU accesses in the window BASE_ADDR..BASE_ADDR+3 here and selects its read data via hit.
- Provides a TX FIFO drained over a valid/ready stream, a 16-bit timer, and control/status registers.
- CPU software (e.g. count32) uses it to emit results without testbench hierarchy peeks.

Parameters:
- ADDR_WIDTH, 12, bus word-address width; matches memory.
- BASE_ADDR, 12'hFFC, window base; low 2 bits must be 0.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- addr  input  ADDR_WIDTH  CPU word address.
- en  input  1  bus access enable.
- rd_en  input  1  read strobe, qualified by en.
- wr_en  input  1  write strobe, qualified by en.
- din  input  16  write data from the CPU.
- dout  output  16  registered read data.
- hit  output  1  registered; dout is valid for this responder in this cycle.
- tx_valid  output  1  stream data valid.
- tx_data  output  16  stream data; the FIFO head.
- tx_ready  input  1  stream sink ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - dout=0, hit=0, tx_valid=0, tx_data=0.
  - FIFO empty, timer=0, CTRL=0, overflow=0.
- Address decode: sel = en & (addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]); off = addr[1:0].
- Access type:
  - Write when sel & wr_en.
  - Read when sel & rd_en & !wr_en; write wins if both strobes are set.
- Read latency is 1 cycle, matching memory:
  - hit is asserted the cycle after a read.
  - dout holds the value sampled at the request edge, i.e. pre-update state of that same edge.
  - Otherwise dout is held and hit=0.
- Register map:
  - off 0 DATA: write pushes din into the FIFO. Reads return 0.
  - off 1 STATUS (read only; writes are ignored):
    - bit0 empty, bit1 full, bit2 overflow (sticky).
    - bits[7:4] count, saturating at 15 in the field.
    - bit8 timer wrap flag (sticky). Other bits 0.
  - off 2 TIMER: read returns the current count. Write loads din; a load takes priority over the increment that cycle.
  - off 3 CTRL:
    - bit0 timer_en is read/write.
    - bit1 written as 1 clears overflow and the wrap flag (write-1-to-clear, self-clearing, reads 0).
    - bit2 irq_en is read/write and is only meaningful with the optional feature.
    - Other bits read 0.
- Timer:
  - Increments every cycle while timer_en=1.
  - Wraps from 16'hFFFF to 0 and sets the wrap flag on that edge.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits with natural wrap-around.
  - tx_valid = !empty; tx_data = mem[rd_ptr], driven combinationally from the registered storage.
  - Pop occurs when tx_valid & tx_ready.
- FIFO boundary conditions:
  - Push when full with no pop that cycle: data is dropped, count is unchanged, overflow is set.
  - Push and pop in the same cycle while full: both take effect, count stays at FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle while empty: the push is accepted, no pop occurs (tx_valid was 0), count becomes 1.
- Reset asserted mid-operation: all state clears immediately and any in-flight read response is discarded (hit=0).

Optional Feature:
- Macro: MEM_IO_RESPONDER_IRQ_EN.
- When defined:
  - Adds output port irq (1 bit, registered, reset 0).
  - irq = irq_en & (wrap flag | overflow), updated every cycle.
  - Clearing both flags via CTRL bit1 drops irq on the next edge.
- When undefined: no irq port. CTRL bit2 is still stored but has no effect.

Decomposition:
- Package mem_io_pkg holds:
  - Register offsets OFF_DATA=2'd0, OFF_STATUS=2'd1, OFF_TIMER=2'd2, OFF_CTRL=2'd3.
  - STATUS/CTRL bit-index constants.
  - A packed struct for CTRL.
- One sub-module, mem_io_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth.
- The top block contains decode, registers, timer and read mux.

Test Plan:
- Reset then read STATUS -> next cycle hit=1, dout=16'h0001; tx_valid=0.
- tx_ready=0; write DATA 16'hA5A5, then 16'h1234 -> tx_valid=1, tx_data=16'hA5A5, STATUS=16'h0020.
  - Raise tx_ready for 2 cycles -> 16'hA5A5 then 16'h1234 are popped, then STATUS=16'h0001.
- tx_ready=0; 9 writes (FIFO_DEPTH=8) -> STATUS=16'h0086; the 9th word is absent from the drained stream.
  - Write CTRL=16'h0002 -> STATUS=16'h0082.
- Fill to 8, then the same cycle push 16'h00FF with tx_ready=1 -> no overflow, count stays 8, 16'h00FF is last out.
- Write TIMER=16'hFFFE, CTRL=16'h0005 -> after 2 cycles the timer is 0 and STATUS bit8=1.
  - With MEM_IO_RESPONDER_IRQ_EN, irq=1 on the following edge; CTRL bit1 write -> irq=0.
- Assert rst_n=0 for 1 ns mid-FIFO-drain and mid-read -> outputs 0 immediately; FIFO empty after release.
